// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the immediate encoder.
//   EOP_*   : extender op codes carried on out_eop
//   state_t : encoder FSM states
package imm_pkg;

  localparam logic [1:0] EOP_SIGN = 2'd0;  // sign-extend imm
  localparam logic [1:0] EOP_ZERO = 2'd1;  // zero-extend imm
  localparam logic [1:0] EOP_LUI  = 2'd2;  // imm << 16
  localparam logic [1:0] EOP_SHL2 = 2'd3;  // sign-extend imm, then << 2

  typedef enum logic [1:0] {
    IDLE,
    EMIT_ONE,
    EMIT_HI,
    EMIT_LO
  } state_t;

endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: valid/ready bundle between producer, encoder and consumer.
//   in_valid/in_ready/in_value         : constant to encode
//   out_valid/out_ready                : beat handshake
//   out_imm/out_eop                    : extender immediate and op
//   out_last/out_or/out_pair           : beat framing flags
// Modports: master = producer/consumer side, slave = encoder side.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_eop;
  logic        out_last;
  logic        out_or;
  logic        out_pair;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_imm, out_eop, out_last, out_or, out_pair
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_imm, out_eop, out_last, out_or, out_pair
  );
endinterface

// File: rtl/imm_encoder_classify.sv
// imm_classify: combinational single-beat fit tests with priority select.
//   value : 32-bit constant
//   fit   : 1 when one extender mode reproduces value
//   imm   : immediate for the selected mode (0 when no fit)
//   eop   : extender op for the selected mode
// Parameter PREFER_ZERO: when 1, zero-extend is chosen over sign-extend.
// Macro IMM_SHL2_EN: enables the sign<<2 fit (EOP_SHL2).
module imm_classify
  import imm_pkg::*;
#(
  parameter int PREFER_ZERO = 0
) (
  input  logic [31:0] value,
  output logic        fit,
  output logic [15:0] imm,
  output logic [1:0]  eop
);

  logic sign_fit;
  logic zero_fit;
  logic lui_fit;
  logic shl2_fit;

  always_comb begin
    sign_fit = (&value[31:15]) || (~|value[31:15]);
    zero_fit = ~|value[31:16];
    lui_fit  = ~|value[15:0];
`ifdef IMM_SHL2_EN
    shl2_fit = (~|value[1:0]) && ((&value[31:17]) || (~|value[31:17]));
`else
    shl2_fit = 1'b0;
`endif
  end

  always_comb begin
    fit = 1'b1;
    imm = '0;
    eop = EOP_SIGN;
    // A value fitting both zero and sign has the same imm; only eop differs.
    if ((PREFER_ZERO != 0) && zero_fit) begin
      imm = value[15:0];
      eop = EOP_ZERO;
    end else if (sign_fit) begin
      imm = value[15:0];
      eop = EOP_SIGN;
    end else if (zero_fit) begin
      imm = value[15:0];
      eop = EOP_ZERO;
    end else if (lui_fit) begin
      imm = value[31:16];
      eop = EOP_LUI;
    end else if (shl2_fit) begin
`ifdef IMM_SHL2_EN
      imm = value[17:2];
      eop = EOP_SHL2;
`endif
    end else begin
      fit = 1'b0;
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: turns a 32-bit constant into one or two extender beats.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : imm_encoder_if.slave (in_* accept side, out_* beat side)
// One beat when a single extender mode fits; otherwise a LUI high half
// followed by a zero-extended low half flagged out_or.
// Parameter PREFER_ZERO: zero-extend wins over sign-extend when both fit.
// Macro IMM_SHL2_EN: allows single-beat EOP_SHL2 encodings.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int PREFER_ZERO = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_encoder_if.slave bus
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] value_q;
  logic [15:0] one_imm_q;
  logic [1:0]  one_eop_q;

  logic        cls_fit;
  logic [15:0] cls_imm;
  logic [1:0]  cls_eop;

  imm_classify #(.PREFER_ZERO(PREFER_ZERO)) u_classify (
    .value (bus.in_value),
    .fit   (cls_fit),
    .imm   (cls_imm),
    .eop   (cls_eop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      value_q   <= '0;
      one_imm_q <= '0;
      one_eop_q <= EOP_SIGN;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.in_valid) begin
        value_q   <= bus.in_value;
        one_imm_q <= cls_imm;
        one_eop_q <= cls_eop;
      end
    end
  end

  // Outputs decode from registered state/data only, so they hold steady
  // while a beat is stalled.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = 1'b0;
    bus.out_imm   = '0;
    bus.out_eop   = EOP_SIGN;
    bus.out_last  = 1'b0;
    bus.out_or    = 1'b0;
    bus.out_pair  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) state_d = cls_fit ? EMIT_ONE : EMIT_HI;
      end
      EMIT_ONE: begin
        bus.out_valid = 1'b1;
        bus.out_imm   = one_imm_q;
        bus.out_eop   = one_eop_q;
        bus.out_last  = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      EMIT_HI: begin
        bus.out_valid = 1'b1;
        bus.out_imm   = value_q[31:16];
        bus.out_eop   = EOP_LUI;
        bus.out_pair  = 1'b1;
        if (bus.out_ready) state_d = EMIT_LO;
      end
      EMIT_LO: begin
        bus.out_valid = 1'b1;
        bus.out_imm   = value_q[15:0];
        bus.out_eop   = EOP_ZERO;
        bus.out_last  = 1'b1;
        bus.out_or    = 1'b1;
        bus.out_pair  = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and round-trip checks for imm_encoder.
// Main DUT uses PREFER_ZERO=0; a second instance uses PREFER_ZERO=1.
// Expectations for 0xFFFE003C follow IMM_SHL2_EN.
module tb_imm_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_encoder_if bus ();
  imm_encoder_if bus_z ();

  imm_encoder #(.PREFER_ZERO(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  imm_encoder #(.PREFER_ZERO(1)) dut_z (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_z.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference extender.
  function automatic logic [31:0] ext(input logic [15:0] imm, input logic [1:0] eop);
    case (eop)
      2'd0:    return {{16{imm[15]}}, imm};
      2'd1:    return {16'h0000, imm};
      2'd2:    return {imm, 16'h0000};
      default: return {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  // Called and returns at a negedge.
  task automatic send(input logic [31:0] v);
    int n;
    bus.in_valid = 1'b1;
    bus.in_value = v;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("latency", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic get_beat(output logic [15:0] imm, output logic [1:0] eop,
                          output logic last, output logic or_, output logic pair);
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat_wait", {31'd0, bus.out_valid}, 32'd1);
    imm  = bus.out_imm;
    eop  = bus.out_eop;
    last = bus.out_last;
    or_  = bus.out_or;
    pair = bus.out_pair;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [15:0] e_imm, input logic [1:0] e_eop,
                             input logic e_last, input logic e_or, input logic e_pair);
    logic [15:0] imm;
    logic [1:0]  eop;
    logic        last, or_, pair;
    get_beat(imm, eop, last, or_, pair);
    check({tag, ".imm"},  {16'd0, imm},  {16'd0, e_imm});
    check({tag, ".eop"},  {30'd0, eop},  {30'd0, e_eop});
    check({tag, ".last"}, {31'd0, last}, {31'd0, e_last});
    check({tag, ".or"},   {31'd0, or_},  {31'd0, e_or});
    check({tag, ".pair"}, {31'd0, pair}, {31'd0, e_pair});
  endtask

  function automatic logic [31:0] gen_value();
    logic [31:0] r;
    logic        b;
    r = $urandom;
    b = r[31];
    case ($urandom_range(0, 5))
      0:       return r;
      1:       return {{17{b}}, r[14:0]};
      2:       return {16'h0000, r[15:0]};
      3:       return {r[15:0], 16'h0000};
      4:       return {{15{b}}, r[14:0], 2'b00};
      default: return {r[31:2], 2'b00};
    endcase
  endfunction

  initial begin
    logic [15:0] imm;
    logic [1:0]  eop;
    logic        last, or_, pair;
    logic [31:0] acc;
    logic [31:0] v;

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_value   = '0;
    bus.out_ready  = 1'b0;
    bus_z.in_valid = 1'b0;
    bus_z.in_value = '0;
    bus_z.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst.in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst.out_imm",   {16'd0, bus.out_imm},   32'd0);
    check("rst.out_eop",   {30'd0, bus.out_eop},   32'd0);
    check("rst.flags", {29'd0, bus.out_last, bus.out_or, bus.out_pair}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(32'hFFFF800F); expect_beat("sign",  16'h800F, 2'd0, 1'b1, 1'b0, 1'b0);
    send(32'h0000800F); expect_beat("zero",  16'h800F, 2'd1, 1'b1, 1'b0, 1'b0);
    send(32'h00001234); expect_beat("both0", 16'h1234, 2'd0, 1'b1, 1'b0, 1'b0);
    send(32'h12340000); expect_beat("lui",   16'h1234, 2'd2, 1'b1, 1'b0, 1'b0);
    send(32'h00000000); expect_beat("zeroval", 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
    send(32'hFFFE003C);
`ifdef IMM_SHL2_EN
    expect_beat("shl2", 16'h800F, 2'd3, 1'b1, 1'b0, 1'b0);
`else
    expect_beat("shl2_hi", 16'hFFFE, 2'd2, 1'b0, 1'b0, 1'b1);
    expect_beat("shl2_lo", 16'h003C, 2'd1, 1'b1, 1'b1, 1'b1);
`endif

    // PREFER_ZERO=1 instance: value fitting both encodes as zero-extend.
    bus_z.in_valid = 1'b1;
    bus_z.in_value = 32'h00001234;
    @(negedge clk);
    bus_z.in_valid = 1'b0;
    check("pz.out_valid", {31'd0, bus_z.out_valid}, 32'd1);
    check("pz.imm",  {16'd0, bus_z.out_imm},  32'h1234);
    check("pz.eop",  {30'd0, bus_z.out_eop},  32'd1);
    check("pz.last", {31'd0, bus_z.out_last}, 32'd1);
    @(negedge clk);
    check("pz.done", {31'd0, bus_z.out_valid}, 32'd0);

    // Stalled pair: fields held, no new input accepted.
    send(32'h12345678);
    for (int i = 0; i < 3; i++) begin
      check("stall.imm",      {16'd0, bus.out_imm},   32'h1234);
      check("stall.eop",      {30'd0, bus.out_eop},   32'd2);
      check("stall.valid",    {31'd0, bus.out_valid}, 32'd1);
      check("stall.in_ready", {31'd0, bus.in_ready},  32'd0);
      @(negedge clk);
    end
    expect_beat("pair_hi", 16'h1234, 2'd2, 1'b0, 1'b0, 1'b1);
    check("pair.in_ready_lo", {31'd0, bus.in_ready}, 32'd0);
    expect_beat("pair_lo", 16'h5678, 2'd1, 1'b1, 1'b1, 1'b1);
    check("pair.in_ready_end", {31'd0, bus.in_ready}, 32'd1);

    // Reset while the low half is pending.
    send(32'h12345678);
    expect_beat("rst_hi", 16'h1234, 2'd2, 1'b0, 1'b0, 1'b1);
    check("rst_mid.valid_before", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid.in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_mid.out_imm",   {16'd0, bus.out_imm},   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid.no_beat", {31'd0, bus.out_valid}, 32'd0);

    // Round-trip sweep through the reference extender.
    for (int i = 0; i < 10000; i++) begin
      v = gen_value();
      send(v);
      get_beat(imm, eop, last, or_, pair);
      acc = ext(imm, eop);
      if (!last) begin
        get_beat(imm, eop, last, or_, pair);
        acc = or_ ? (acc | ext(imm, eop)) : ext(imm, eop);
      end
      check($sformatf("roundtrip[%08h]", v), acc, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
